bsg_dmc_ui_mux: RTL and testbench
=================================

Name: bsg_dmc_ui_mux

Overview:
- Parametrised N-channel multiplexer onto one DMC user-interface port (app_* command, write-data and read-data channels).
- Successor to the fixed two-source test-mode/user select. Supports any number of requesters, such as several trace-replay engines plus user logic.
- Arbitrates commands round-robin and steers write data to the channel that owns each accepted write.
- Routes returning read data back to the issuing channel in order. Sits between requesters and bsg_dmc in the ui_clk domain.

Parameters:
- num_ch_p, 4, number of requester channels (≥2).
- addr_width_p, 28, UI address width.
- data_width_p, 32, UI data width (multiple of 8).
- order_depth_p, 8, depth of each ownership FIFO (power of 2, ≥2).

Ports:
- clk_i  in  1  UI clock.
- reset_i  in  1  synchronous active-high reset.
- ch_addr_i  in  num_ch_p*addr_width_p  per-channel address, channel c at slice c.
- ch_cmd_i  in  num_ch_p*3  per-channel app_cmd_e.
- ch_en_i  in  num_ch_p  command valid.
- ch_rdy_o  out  num_ch_p  command accepted this cycle.
- ch_wdf_wren_i  in  num_ch_p  write-data valid.
- ch_wdf_data_i  in  num_ch_p*data_width_p  write data.
- ch_wdf_mask_i  in  num_ch_p*(data_width_p/8)  write mask.
- ch_wdf_end_i  in  num_ch_p  last write beat.
- ch_wdf_rdy_o  out  num_ch_p  write beat accepted.
- ch_rd_data_valid_o  out  num_ch_p  read beat for channel c.
- ch_rd_data_o  out  data_width_p  read data, shared by all channels.
- ch_rd_data_end_o  out  num_ch_p  last read beat for channel c.
- app_addr_o, app_cmd_o, app_en_o  out  addr_width_p / 3 / 1  to DMC.
- app_rdy_i  in  1  from DMC.
- app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o  out  1 / data_width_p / data_width_p/8 / 1  to DMC.
- app_wdf_rdy_i  in  1  from DMC.
- app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i  in  1 / data_width_p / 1  from DMC.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on reset_i.
- During and after reset: all FIFOs empty, round-robin pointer = 0, err_o = 0, all app_*_o and ch_*_o outputs = 0.
- Command classes: cmd==3'b001 is a read; every other encoding is write-class.
- Command arbitration is combinational, zero latency.
  - Eligible channel: ch_en_i=1 and its class FIFO (wr_own or rd_own) is not full.
  - Grant the first eligible channel at or after the pointer, wrapping modulo num_ch_p.
  - app_en_o=1 with the granted channel's addr/cmd; all other address bits are 0.
  - ch_rdy_o[g] = app_rdy_i & grant[g].
- On accept (app_en_o & app_rdy_i):
  - Push g into wr_own (write-class) or rd_own (read).
  - Pointer ← (g+1) mod num_ch_p.
  - With no accept, the pointer holds.
- Write data path:
  - Head of wr_own = owner.
  - If wr_own is non-empty: app_wdf_* mirror the owner's inputs; ch_wdf_rdy_o[owner] = app_wdf_rdy_i; all other channels see 0.
  - Pop on an accepted beat with wdf_end=1.
  - If wr_own is empty: app_wdf_wren_o=0 and no channel is ready. Data never precedes its command.
- Read return path:
  - Head of rd_own = destination.
  - app_rd_data_i is forwarded unregistered to ch_rd_data_o.
  - ch_rd_data_valid_o[dest] = app_rd_data_valid_i; ch_rd_data_end_o[dest] = app_rd_data_end_i.
  - Pop when valid & end.
  - Valid while rd_own is empty: beat dropped, err_o←1.
- Simultaneous events:
  - Push and pop of the same FIFO in one cycle is allowed, including when full (count unchanged).
  - FIFO full blocks only that class; the other class still arbitrates.
- err_o stays set until reset. A wdf_end seen on the owner while wr_own is empty cannot occur, because ready is withheld.
- Reset mid-operation: in-flight ownership is discarded, and the DMC must be reset together with this block.

Optional Feature:
- Macro: BSG_DMC_UI_MUX_STATS_EN.
- When defined:
  - Adds output stats_o, num_ch_p*32, with per-channel counts of accepted commands.
  - Counters saturate at 2^32-1 and clear on reset.
- When undefined: no port and no counter logic.

Test Plan:
- Single channel, all cycles: ch 2 issues read @0x100, app_rdy_i=1 → app_addr_o=0x100 in the same cycle; a 2-beat return raises ch_rd_data_valid_o=4'b0100, with end on beat 2.
- Round-robin fairness: all 4 channels assert en with app_rdy_i held 1 → grants in order 0,1,2,3,0,…; each channel gets exactly 25 of 100 grants.
- Write ordering: writes accepted from ch 3 then ch 1; ch 1 presents data first → ch_wdf_rdy_o stays 0 for ch 1 until ch 3's end beat is accepted.
- Backpressure: fill rd_own with 8 reads → further reads get no grant, while a write from another channel is still accepted the same cycle.
- Full push/pop: rd_own is full, and a read return end coincides with a new read accept → accept succeeds and occupancy stays 8.
- Error and reset: app_rd_data_valid_i=1 with rd_own empty → no channel valid and err_o=1; synchronous reset_i clears err_o and the FIFOs on the next edge.

Source files
------------

// File: rtl/bsg_dmc_ui_mux_if.sv
// Bundle of per-channel requester signals and the single DMC app_* port.
// Signal names keep the DMC user-interface naming so both sides read naturally.
interface bsg_dmc_ui_mux_if #(
    parameter int unsigned num_ch_p     = 4,
    parameter int unsigned addr_width_p = 28,
    parameter int unsigned data_width_p = 32
);
    localparam int unsigned mask_w = data_width_p / 8;

    // requester side
    logic [num_ch_p*addr_width_p-1:0] ch_addr_i;
    logic [num_ch_p*3-1:0]            ch_cmd_i;
    logic [num_ch_p-1:0]              ch_en_i;
    logic [num_ch_p-1:0]              ch_rdy_o;
    logic [num_ch_p-1:0]              ch_wdf_wren_i;
    logic [num_ch_p*data_width_p-1:0] ch_wdf_data_i;
    logic [num_ch_p*mask_w-1:0]       ch_wdf_mask_i;
    logic [num_ch_p-1:0]              ch_wdf_end_i;
    logic [num_ch_p-1:0]              ch_wdf_rdy_o;
    logic [num_ch_p-1:0]              ch_rd_data_valid_o;
    logic [data_width_p-1:0]          ch_rd_data_o;
    logic [num_ch_p-1:0]              ch_rd_data_end_o;

    // DMC side
    logic [addr_width_p-1:0]          app_addr_o;
    logic [2:0]                       app_cmd_o;
    logic                             app_en_o;
    logic                             app_rdy_i;
    logic                             app_wdf_wren_o;
    logic [data_width_p-1:0]          app_wdf_data_o;
    logic [mask_w-1:0]                app_wdf_mask_o;
    logic                             app_wdf_end_o;
    logic                             app_wdf_rdy_i;
    logic                             app_rd_data_valid_i;
    logic [data_width_p-1:0]          app_rd_data_i;
    logic                             app_rd_data_end_i;

    // the mux itself
    modport slave (
        input  ch_addr_i, ch_cmd_i, ch_en_i, ch_wdf_wren_i, ch_wdf_data_i,
               ch_wdf_mask_i, ch_wdf_end_i, app_rdy_i, app_wdf_rdy_i,
               app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i,
        output ch_rdy_o, ch_wdf_rdy_o, ch_rd_data_valid_o, ch_rd_data_o,
               ch_rd_data_end_o, app_addr_o, app_cmd_o, app_en_o,
               app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o
    );

    // the environment (requesters plus DMC)
    modport master (
        output ch_addr_i, ch_cmd_i, ch_en_i, ch_wdf_wren_i, ch_wdf_data_i,
               ch_wdf_mask_i, ch_wdf_end_i, app_rdy_i, app_wdf_rdy_i,
               app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i,
        input  ch_rdy_o, ch_wdf_rdy_o, ch_rd_data_valid_o, ch_rd_data_o,
               ch_rd_data_end_o, app_addr_o, app_cmd_o, app_en_o,
               app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o
    );
endinterface

// File: rtl/bsg_dmc_ui_mux.sv
// N-channel multiplexer onto one DMC user-interface port.
// Commands are arbitrated round-robin with zero latency; two ownership FIFOs
// remember which channel owns each outstanding write and read so that write
// data and read returns are steered in command order.
// Optional: define BSG_DMC_UI_MUX_STATS_EN to add per-channel accepted-command
// counters on stats_o.

// Small ownership FIFO holding channel indices; push and pop may coincide even when full.
module bsg_dmc_ui_mux_fifo #(
    parameter int unsigned width_p = 2,
    parameter int unsigned depth_p = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [width_p-1:0] push_data,
    input  logic               pop,
    output logic [width_p-1:0] head,
    output logic               full,
    output logic               empty
);
    localparam int unsigned ptr_w = $clog2(depth_p);
    localparam int unsigned cnt_w = ptr_w + 1;

    logic [width_p-1:0] mem [depth_p];
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [cnt_w-1:0]   count;

    // storage write; contents need no reset because empty gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            if (push && !pop) begin
                count <= count + cnt_w'(1);
            end else if (!push && pop) begin
                count <= count - cnt_w'(1);
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == cnt_w'(depth_p));
    assign empty = (count == '0);
endmodule

module bsg_dmc_ui_mux #(
    parameter int unsigned num_ch_p      = 4,
    parameter int unsigned addr_width_p  = 28,
    parameter int unsigned data_width_p  = 32,
    parameter int unsigned order_depth_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bsg_dmc_ui_mux_if.slave         ui,
`ifdef BSG_DMC_UI_MUX_STATS_EN
    output logic [num_ch_p*32-1:0]  stats_o,
`endif
    output logic                    err_o
);
    localparam int unsigned idx_w  = $clog2(num_ch_p);
    localparam int unsigned mask_w = data_width_p / 8;
    localparam logic [2:0]  cmd_read = 3'b001;

    logic [idx_w-1:0]        rr_ptr;
    logic [idx_w-1:0]        grant_idx;
    logic                    grant_v;
    logic                    accept;
    logic                    grant_read;
    logic [num_ch_p-1:0]     is_read;
    logic [num_ch_p-1:0]     eligible;
    logic [num_ch_p-1:0]     ch_rdy;
    logic [addr_width_p-1:0] app_addr;
    logic [2:0]              app_cmd;

    logic                    wr_push, wr_pop, wr_full, wr_empty, wr_room;
    logic                    rd_push, rd_pop, rd_full, rd_empty, rd_room;
    logic [idx_w-1:0]        wr_head;
    logic [idx_w-1:0]        rd_head;

    logic                    wdf_wren;
    logic [data_width_p-1:0] wdf_data;
    logic [mask_w-1:0]       wdf_mask;
    logic                    wdf_end;
    logic [num_ch_p-1:0]     wdf_rdy;

    logic [num_ch_p-1:0]     rd_valid;
    logic [num_ch_p-1:0]     rd_end;
    logic                    rd_drop;

    // write data follows the channel at the head of the write-ownership FIFO
    always_comb begin
        wdf_wren = 1'b0;
        wdf_data = '0;
        wdf_mask = '0;
        wdf_end  = 1'b0;
        wdf_rdy  = '0;
        if (!reset_i && !wr_empty) begin
            for (int unsigned c = 0; c < num_ch_p; c++) begin
                if (idx_w'(c) == wr_head) begin
                    wdf_wren   = ui.ch_wdf_wren_i[c];
                    wdf_data   = ui.ch_wdf_data_i[c*data_width_p +: data_width_p];
                    wdf_mask   = ui.ch_wdf_mask_i[c*mask_w +: mask_w];
                    wdf_end    = ui.ch_wdf_end_i[c];
                    wdf_rdy[c] = ui.app_wdf_rdy_i;
                end
            end
        end
        wr_pop = wdf_wren && wdf_end && ui.app_wdf_rdy_i;
    end

    // read returns go to the channel at the head of the read-ownership FIFO
    always_comb begin
        rd_valid = '0;
        rd_end   = '0;
        rd_pop   = 1'b0;
        rd_drop  = 1'b0;
        if (!reset_i) begin
            if (rd_empty) begin
                rd_drop = ui.app_rd_data_valid_i;
            end else begin
                for (int unsigned c = 0; c < num_ch_p; c++) begin
                    if (idx_w'(c) == rd_head) begin
                        rd_valid[c] = ui.app_rd_data_valid_i;
                        rd_end[c]   = ui.app_rd_data_end_i;
                    end
                end
                rd_pop = ui.app_rd_data_valid_i && ui.app_rd_data_end_i;
            end
        end
    end

    // a pop in the same cycle frees a slot, so a full FIFO can still accept
    assign wr_room = !wr_full || wr_pop;
    assign rd_room = !rd_full || rd_pop;

    // eligibility: command pending and its class FIFO has room
    always_comb begin
        is_read  = '0;
        eligible = '0;
        for (int unsigned c = 0; c < num_ch_p; c++) begin
            is_read[c]  = (ui.ch_cmd_i[c*3 +: 3] == cmd_read);
            eligible[c] = !reset_i && ui.ch_en_i[c] && (is_read[c] ? rd_room : wr_room);
        end
    end

    // round-robin search: channels at/after the pointer first, then wrap from 0
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        for (int unsigned c = 0; c < num_ch_p; c++) begin
            if (!grant_v && eligible[c] && (idx_w'(c) >= rr_ptr)) begin
                grant_v   = 1'b1;
                grant_idx = idx_w'(c);
            end
        end
        for (int unsigned c = 0; c < num_ch_p; c++) begin
            if (!grant_v && eligible[c]) begin
                grant_v   = 1'b1;
                grant_idx = idx_w'(c);
            end
        end
    end

    // present the granted command to the DMC
    always_comb begin
        app_addr = '0;
        app_cmd  = '0;
        ch_rdy   = '0;
        for (int unsigned c = 0; c < num_ch_p; c++) begin
            if (grant_v && (idx_w'(c) == grant_idx)) begin
                app_addr  = ui.ch_addr_i[c*addr_width_p +: addr_width_p];
                app_cmd   = ui.ch_cmd_i[c*3 +: 3];
                ch_rdy[c] = ui.app_rdy_i;
            end
        end
    end

    assign accept     = grant_v && ui.app_rdy_i;
    assign grant_read = (app_cmd == cmd_read);
    assign rd_push    = accept && grant_read;
    assign wr_push    = accept && !grant_read;

    bsg_dmc_ui_mux_fifo #(
        .width_p (idx_w),
        .depth_p (order_depth_p)
    ) wr_own (
        .clk       (clk_i),
        .reset     (reset_i),
        .push      (wr_push),
        .push_data (grant_idx),
        .pop       (wr_pop),
        .head      (wr_head),
        .full      (wr_full),
        .empty     (wr_empty)
    );

    bsg_dmc_ui_mux_fifo #(
        .width_p (idx_w),
        .depth_p (order_depth_p)
    ) rd_own (
        .clk       (clk_i),
        .reset     (reset_i),
        .push      (rd_push),
        .push_data (grant_idx),
        .pop       (rd_pop),
        .head      (rd_head),
        .full      (rd_full),
        .empty     (rd_empty)
    );

    // pointer moves just past the winner on accept, otherwise holds
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == idx_w'(num_ch_p - 1)) ? '0 : grant_idx + idx_w'(1);
        end
    end

    // sticky flag for read data arriving with no outstanding read
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_o <= 1'b0;
        end else if (rd_drop) begin
            err_o <= 1'b1;
        end
    end

`ifdef BSG_DMC_UI_MUX_STATS_EN
    // saturating count of accepted commands per channel
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stats_o <= '0;
        end else begin
            for (int unsigned c = 0; c < num_ch_p; c++) begin
                if (ch_rdy[c] && (stats_o[c*32 +: 32] != 32'hFFFF_FFFF)) begin
                    stats_o[c*32 +: 32] <= stats_o[c*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif

    assign ui.app_addr_o         = app_addr;
    assign ui.app_cmd_o          = app_cmd;
    assign ui.app_en_o           = grant_v;
    assign ui.ch_rdy_o           = ch_rdy;
    assign ui.app_wdf_wren_o     = wdf_wren;
    assign ui.app_wdf_data_o     = wdf_data;
    assign ui.app_wdf_mask_o     = wdf_mask;
    assign ui.app_wdf_end_o      = wdf_end;
    assign ui.ch_wdf_rdy_o       = wdf_rdy;
    assign ui.ch_rd_data_valid_o = rd_valid;
    assign ui.ch_rd_data_end_o   = rd_end;
    assign ui.ch_rd_data_o       = reset_i ? '0 : ui.app_rd_data_i;
endmodule

// File: tb/tb_bsg_dmc_ui_mux.sv
// Self-checking bench for bsg_dmc_ui_mux (4 channels, default widths).
module tb_bsg_dmc_ui_mux;
    localparam int unsigned nc = 4;
    localparam int unsigned aw = 28;
    localparam int unsigned dw = 32;
    localparam int unsigned mw = dw / 8;

    logic clk = 1'b0;
    logic reset;
    logic err;
`ifdef BSG_DMC_UI_MUX_STATS_EN
    logic [nc*32-1:0] stats;
`endif

    always #5 clk = ~clk;

    bsg_dmc_ui_mux_if #(.num_ch_p(nc), .addr_width_p(aw), .data_width_p(dw)) ui ();

    bsg_dmc_ui_mux #(
        .num_ch_p      (nc),
        .addr_width_p  (aw),
        .data_width_p  (dw),
        .order_depth_p (8)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .ui      (ui),
`ifdef BSG_DMC_UI_MUX_STATS_EN
        .stats_o (stats),
`endif
        .err_o   (err)
    );

    int checks   = 0;
    int failures = 0;
    int rd_exp_q[$];
    int wr_exp_q[$];

    typedef struct packed {
        logic [3:0]  en;
        logic [3:0]  rd;
        logic        rdy;
        logic        exp_en;
        logic [3:0]  exp_rdy;
        logic [27:0] exp_addr;
        logic [2:0]  exp_cmd;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int c = 0; c < 4; c++) begin
            if (v[c]) return c;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic en, input logic rd);
        ui.ch_en_i[c]          = en;
        ui.ch_cmd_i[c*3 +: 3]  = rd ? 3'b001 : 3'b000;
    endtask

    task automatic set_wdf(input int c, input logic wren, input logic last, input logic [31:0] d);
        ui.ch_wdf_wren_i[c]          = wren;
        ui.ch_wdf_end_i[c]           = last;
        ui.ch_wdf_data_i[c*dw +: dw] = d;
        ui.ch_wdf_mask_i[c*mw +: mw] = 4'(c);
    endtask

    task automatic idle();
        for (int c = 0; c < 4; c++) begin
            ui.ch_addr_i[c*aw +: aw] = 28'hA00 + 28'(c);
            set_ch(c, 1'b0, 1'b0);
            set_wdf(c, 1'b0, 1'b0, 32'h0);
        end
        ui.app_rdy_i           = 1'b0;
        ui.app_wdf_rdy_i       = 1'b0;
        ui.app_rd_data_valid_i = 1'b0;
        ui.app_rd_data_i       = '0;
        ui.app_rd_data_end_i   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // expected arbitration from a fresh pointer of 0 (bits: ch3..ch0)
        tbl[0] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 28'h000, 3'b000};
        tbl[1] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0000, 28'hA00, 3'b000};
        tbl[2] = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0001, 28'hA00, 3'b000};
        tbl[3] = '{4'b1001, 4'b0000, 1'b1, 1'b1, 4'b1000, 28'hA03, 3'b000};
        tbl[4] = '{4'b0110, 4'b0000, 1'b1, 1'b1, 4'b0010, 28'hA01, 3'b000};
        tbl[5] = '{4'b0011, 4'b0000, 1'b1, 1'b1, 4'b0001, 28'hA00, 3'b000};
        tbl[6] = '{4'b1100, 4'b1100, 1'b1, 1'b1, 4'b0100, 28'hA02, 3'b001};
        tbl[7] = '{4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0100, 28'hA02, 3'b001};
        tbl[8] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 28'h000, 3'b000};

        // reset with every input active: outputs must be quiet
        idle();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_ch(c, 1'b1, c[0]);
            set_wdf(c, 1'b1, 1'b1, 32'h5555_0000 + 32'(c));
        end
        ui.app_rdy_i = 1'b1;
        ui.app_wdf_rdy_i = 1'b1;
        ui.app_rd_data_valid_i = 1'b1;
        ui.app_rd_data_end_i = 1'b1;
        @(posedge clk);
        #4;
        chk("rst_app_en", 64'(ui.app_en_o), 64'(0));
        chk("rst_ch_rdy", 64'(ui.ch_rdy_o), 64'(0));
        chk("rst_app_addr", 64'(ui.app_addr_o), 64'(0));
        chk("rst_wdf_wren", 64'(ui.app_wdf_wren_o), 64'(0));
        chk("rst_rd_valid", 64'(ui.ch_rd_data_valid_o), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        tick();
        do_reset();

        // single read from ch2 at 0x100, two-beat return
        ui.ch_addr_i[2*aw +: aw] = 28'h100;
        set_ch(2, 1'b1, 1'b1);
        ui.app_rdy_i = 1'b1;
        #4;
        chk("single_addr", 64'(ui.app_addr_o), 64'h100);
        chk("single_en", 64'(ui.app_en_o), 64'(1));
        chk("single_cmd", 64'(ui.app_cmd_o), 64'(1));
        chk("single_rdy", 64'(ui.ch_rdy_o), 64'b0100);
        tick();
        idle();
        ui.app_rd_data_valid_i = 1'b1;
        ui.app_rd_data_i = 32'hCAFE_0001;
        #4;
        chk("single_b1_valid", 64'(ui.ch_rd_data_valid_o), 64'b0100);
        chk("single_b1_end", 64'(ui.ch_rd_data_end_o), 64'b0000);
        chk("single_b1_data", 64'(ui.ch_rd_data_o), 64'hCAFE_0001);
        tick();
        ui.app_rd_data_end_i = 1'b1;
        ui.app_rd_data_i = 32'hCAFE_0002;
        #4;
        chk("single_b2_valid", 64'(ui.ch_rd_data_valid_o), 64'b0100);
        chk("single_b2_end", 64'(ui.ch_rd_data_end_o), 64'b0100);
        tick();
        idle();
        #4;
        chk("single_after_valid", 64'(ui.ch_rd_data_valid_o), 64'(0));
        tick();

        // table-driven arbitration from a fresh pointer
        do_reset();
        for (int i = 0; i < 9; i++) begin
            for (int c = 0; c < 4; c++) set_ch(c, tbl[i].en[c], tbl[i].rd[c]);
            ui.app_rdy_i = tbl[i].rdy;
            #4;
            chk($sformatf("tbl%0d_en", i), 64'(ui.app_en_o), 64'(tbl[i].exp_en));
            chk($sformatf("tbl%0d_rdy", i), 64'(ui.ch_rdy_o), 64'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_addr", i), 64'(ui.app_addr_o), 64'(tbl[i].exp_addr));
            chk($sformatf("tbl%0d_cmd", i), 64'(ui.app_cmd_o), 64'(tbl[i].exp_cmd));
            if (tbl[i].exp_en && tbl[i].rdy) begin
                if (tbl[i].exp_cmd == 3'b001) rd_exp_q.push_back(oh_idx(tbl[i].exp_rdy));
                else wr_exp_q.push_back(oh_idx(tbl[i].exp_rdy));
            end
            tick();
        end
        idle();

        // scoreboard: two-beat read returns in issue order
        while (rd_exp_q.size() > 0) begin
            int own;
            own = rd_exp_q.pop_front();
            ui.app_rd_data_valid_i = 1'b1;
            ui.app_rd_data_end_i = 1'b0;
            ui.app_rd_data_i = 32'hBEEF_0000 + 32'(own);
            #4;
            chk("sb_rd_valid", 64'(ui.ch_rd_data_valid_o), 64'(1) << own);
            chk("sb_rd_data", 64'(ui.ch_rd_data_o), 64'h0BEEF_0000 + 64'(own));
            tick();
            ui.app_rd_data_end_i = 1'b1;
            #4;
            chk("sb_rd_end", 64'(ui.ch_rd_data_end_o), 64'(1) << own);
            tick();
        end
        idle();

        // scoreboard: single-beat writes drained in accept order
        for (int c = 0; c < 4; c++) set_wdf(c, 1'b1, 1'b1, 32'hD000_0000 + 32'(c));
        ui.app_wdf_rdy_i = 1'b1;
        while (wr_exp_q.size() > 0) begin
            int own;
            own = wr_exp_q.pop_front();
            #4;
            chk("sb_wdf_rdy", 64'(ui.ch_wdf_rdy_o), 64'(1) << own);
            chk("sb_wdf_data", 64'(ui.app_wdf_data_o), 64'h0D000_0000 + 64'(own));
            chk("sb_wdf_mask", 64'(ui.app_wdf_mask_o), 64'(own));
            tick();
        end
        #4;
        chk("sb_wdf_empty_wren", 64'(ui.app_wdf_wren_o), 64'(0));
        chk("sb_wdf_empty_rdy", 64'(ui.ch_wdf_rdy_o), 64'(0));
        tick();

        // fairness over 100 grants with write data draining every cycle
        do_reset();
        begin
            int gcnt[4];
            for (int c = 0; c < 4; c++) gcnt[c] = 0;
            for (int c = 0; c < 4; c++) begin
                set_ch(c, 1'b1, 1'b0);
                set_wdf(c, 1'b1, 1'b1, 32'hF000_0000 + 32'(c));
            end
            ui.app_rdy_i = 1'b1;
            ui.app_wdf_rdy_i = 1'b1;
            for (int k = 0; k < 100; k++) begin
                int g;
                g = k % 4;
                #4;
                chk("rr_grant", 64'(ui.ch_rdy_o), 64'(1) << g);
                if (wr_exp_q.size() > 0) chk("rr_wdf_owner", 64'(ui.ch_wdf_rdy_o), 64'(1) << wr_exp_q.pop_front());
                else chk("rr_wdf_none", 64'(ui.ch_wdf_rdy_o), 64'(0));
                for (int c = 0; c < 4; c++) if (ui.ch_rdy_o[c]) gcnt[c]++;
                wr_exp_q.push_back(g);
                tick();
            end
            idle();
            for (int c = 0; c < 4; c++) chk($sformatf("rr_count%0d", c), 64'(gcnt[c]), 64'(25));
`ifdef BSG_DMC_UI_MUX_STATS_EN
            for (int c = 0; c < 4; c++) chk($sformatf("stats%0d", c), 64'(stats[c*32 +: 32]), 64'(25));
`endif
            wr_exp_q.delete();
        end

        // write ordering: ch3 then ch1 accepted, ch1 data offered first
        do_reset();
        set_ch(3, 1'b1, 1'b0);
        ui.app_rdy_i = 1'b1;
        ui.app_wdf_rdy_i = 1'b1;
        #4;
        chk("wo_acc3", 64'(ui.ch_rdy_o), 64'b1000);
        tick();
        set_ch(3, 1'b0, 1'b0);
        set_ch(1, 1'b1, 1'b0);
        set_wdf(1, 1'b1, 1'b1, 32'h1111_1111);
        #4;
        chk("wo_acc1", 64'(ui.ch_rdy_o), 64'b0010);
        chk("wo_hold1_rdy", 64'(ui.ch_wdf_rdy_o), 64'b1000);
        chk("wo_hold1_wren", 64'(ui.app_wdf_wren_o), 64'(0));
        tick();
        set_ch(1, 1'b0, 1'b0);
        set_wdf(3, 1'b1, 1'b0, 32'h3333_0001);
        #4;
        chk("wo_b1_rdy", 64'(ui.ch_wdf_rdy_o), 64'b1000);
        chk("wo_b1_data", 64'(ui.app_wdf_data_o), 64'h3333_0001);
        chk("wo_b1_end", 64'(ui.app_wdf_end_o), 64'(0));
        tick();
        set_wdf(3, 1'b1, 1'b1, 32'h3333_0002);
        #4;
        chk("wo_b2_rdy", 64'(ui.ch_wdf_rdy_o), 64'b1000);
        chk("wo_b2_end", 64'(ui.app_wdf_end_o), 64'(1));
        tick();
        set_wdf(3, 1'b0, 1'b0, 32'h0);
        #4;
        chk("wo_ch1_rdy", 64'(ui.ch_wdf_rdy_o), 64'b0010);
        chk("wo_ch1_data", 64'(ui.app_wdf_data_o), 64'h1111_1111);
        tick();
        set_wdf(1, 1'b0, 1'b0, 32'h0);
        #4;
        chk("wo_done_rdy", 64'(ui.ch_wdf_rdy_o), 64'(0));
        tick();

        // backpressure: eight reads fill the read-ownership FIFO
        do_reset();
        ui.app_rdy_i = 1'b1;
        set_ch(0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            #4;
            chk("bp_fill", 64'(ui.ch_rdy_o), 64'b0001);
            tick();
        end
        #4;
        chk("bp_full_en", 64'(ui.app_en_o), 64'(0));
        chk("bp_full_rdy", 64'(ui.ch_rdy_o), 64'(0));
        tick();
        set_ch(0, 1'b0, 1'b0);
        set_ch(1, 1'b1, 1'b1);
        set_ch(2, 1'b1, 1'b0);
        #4;
        chk("bp_write_pass", 64'(ui.ch_rdy_o), 64'b0100);
        chk("bp_write_cmd", 64'(ui.app_cmd_o), 64'(0));
        tick();

        // full FIFO: return end coincides with a new read accept
        set_ch(1, 1'b0, 1'b0);
        set_ch(2, 1'b0, 1'b0);
        set_ch(0, 1'b1, 1'b1);
        ui.app_rd_data_valid_i = 1'b1;
        ui.app_rd_data_end_i = 1'b1;
        #4;
        chk("pp_accept", 64'(ui.ch_rdy_o), 64'b0001);
        chk("pp_ret_valid", 64'(ui.ch_rd_data_valid_o), 64'b0001);
        tick();
        ui.app_rd_data_valid_i = 1'b0;
        #4;
        chk("pp_still_full", 64'(ui.ch_rdy_o), 64'(0));
        tick();
        set_ch(0, 1'b0, 1'b0);
        ui.app_rd_data_valid_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #4;
            chk("pp_drain", 64'(ui.ch_rd_data_valid_o), 64'b0001);
            tick();
        end

        // stray read beat with nothing outstanding
        #4;
        chk("err_drop_valid", 64'(ui.ch_rd_data_valid_o), 64'(0));
        chk("err_before", 64'(err), 64'(0));
        tick();
        ui.app_rd_data_valid_i = 1'b0;
        #4;
        chk("err_set", 64'(err), 64'(1));
        tick();
        #4;
        chk("err_sticky", 64'(err), 64'(1));
        tick();

        // synchronous reset clears err and pending write ownership (ch2)
        reset = 1'b1;
        set_wdf(2, 1'b1, 1'b1, 32'h2222_2222);
        ui.app_wdf_rdy_i = 1'b1;
        #4;
        chk("rst2_wdf_wren", 64'(ui.app_wdf_wren_o), 64'(0));
        tick();
        reset = 1'b0;
        #4;
        chk("rst2_err", 64'(err), 64'(0));
        chk("rst2_wdf_rdy", 64'(ui.ch_wdf_rdy_o), 64'(0));
        chk("rst2_wdf_wren_after", 64'(ui.app_wdf_wren_o), 64'(0));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
